biriscv_mem_arbiter: RTL and testbench

- Shares the single-port core RAM (20-bit word address, 32-bit data) between the core's instruction-fetch port and its data port.
- Both requester ports use req/gnt/rvalid handshakes. The RAM side is a plain req/we/addr/wdata/strb port with fixed read latency.
- Sits between riscv_core and biriscv_ram in the memory top level.
- Provides:
  - arbitration with data priority and an instruction starvation guard;
  - response routing through a latency-matched tag pipeline;
  - out-of-range error responses;
  - per-port grant counters, readable by the fuzzer harness.

---
 rtl/biriscv_mem_pkg.sv | 20 ++
 rtl/biriscv_mem_resp_pipe.sv | 37 +++
 rtl/biriscv_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_biriscv_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_mem_pkg.sv
// Shared types for the core RAM arbiter: response owner and the per-grant
// tag that travels alongside the RAM read latency.
package biriscv_mem_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // wr marks write responses so their rdata is forced to zero at the output
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
        logic   wr;
    } resp_tag_t;

    localparam int RAM_MAX_LATENCY = 4;

endpackage

// File: rtl/biriscv_mem_resp_pipe.sv
// Latency-matched shift register of response tags; flush clears every stage
// so no response from before a reset can surface afterwards.
module biriscv_mem_resp_pipe
    import biriscv_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      i_clk,
    input  logic      i_flush,
    input  resp_tag_t i_tag,
    output resp_tag_t o_tag
);

    generate
        if (LATENCY < 1 || LATENCY > RAM_MAX_LATENCY) begin : g_bad_latency
            $error("biriscv_mem_resp_pipe: LATENCY out of range");
        end
    endgenerate

    resp_tag_t r_stage [LATENCY];

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[LATENCY-1];

endmodule

// File: rtl/biriscv_mem_arbiter.sv
// Shares the single-port core RAM between instruction fetch and data ports:
// data has priority, a starvation counter forces fetch through periodically.
module biriscv_mem_arbiter
    import biriscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int RAM_LATENCY = 1,
    parameter int STARVE_MAX  = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,

    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_strb_o,
    input  logic [31:0]           ram_rdata_i,

    output logic [CNT_WIDTH-1:0]  instr_cnt_o,
    output logic [CNT_WIDTH-1:0]  data_cnt_o
);

    localparam int              SW         = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX - 1);

    logic [SW-1:0]        r_starve_cnt;
    logic [CNT_WIDTH-1:0] r_instr_cnt;
    logic [CNT_WIDTH-1:0] r_data_cnt;

    logic      w_instr_oor;
    logic      w_data_oor;
    logic      w_starved;
    logic      w_instr_gnt;
    logic      w_data_gnt;
    logic      w_sel_oor;
    logic      w_ram_req;
    logic      w_ram_data;
    logic      w_instr_resp;
    logic      w_data_resp;
    logic      w_resp_has_data;
    resp_tag_t w_tag_in;
    resp_tag_t w_tag_out;

    assign w_instr_oor = (instr_addr_i >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_data_oor  = (data_addr_i  >> (ADDR_WIDTH + 2)) != 32'd0;

    // Grants are gated by reset so every output reads 0 while rst_i is high
    assign w_starved   = (r_starve_cnt == STARVE_LIM);
    assign w_instr_gnt = ~rst_i & instr_req_i & (~data_req_i | w_starved);
    assign w_data_gnt  = ~rst_i & data_req_i & ~w_instr_gnt;

    assign w_sel_oor  = w_data_gnt ? w_data_oor : w_instr_oor;
    assign w_ram_req  = (w_instr_gnt | w_data_gnt) & ~w_sel_oor;
    assign w_ram_data = w_ram_req & w_data_gnt;

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    assign ram_req_o   = w_ram_req;
    assign ram_we_o    = w_ram_data & data_we_i;
    assign ram_strb_o  = w_ram_data ? data_be_i : 4'b0000;
    assign ram_wdata_o = (w_ram_data & data_we_i) ? data_wdata_i : 32'd0;
    assign ram_addr_o  = ~w_ram_req ? '0 :
                         w_data_gnt ? data_addr_i[ADDR_WIDTH+1:2] :
                                      instr_addr_i[ADDR_WIDTH+1:2];

    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_instr_gnt | w_data_gnt;
        w_tag_in.owner = w_data_gnt ? OWN_DATA : OWN_INSTR;
        w_tag_in.err   = (w_instr_gnt | w_data_gnt) & w_sel_oor;
        w_tag_in.wr    = w_data_gnt & data_we_i;
    end

    biriscv_mem_resp_pipe #(
        .LATENCY (RAM_LATENCY)
    ) u_resp_pipe (
        .i_clk   (clk_i),
        .i_flush (rst_i),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    assign w_instr_resp    = ~rst_i & w_tag_out.valid & (w_tag_out.owner == OWN_INSTR);
    assign w_data_resp     = ~rst_i & w_tag_out.valid & (w_tag_out.owner == OWN_DATA);
    assign w_resp_has_data = ~w_tag_out.err & ~w_tag_out.wr;

    assign instr_rvalid_o = w_instr_resp;
    assign instr_err_o    = w_instr_resp & w_tag_out.err;
    assign instr_rdata_o  = (w_instr_resp & w_resp_has_data) ? ram_rdata_i : 32'd0;

    assign data_rvalid_o  = w_data_resp;
    assign data_err_o     = w_data_resp & w_tag_out.err;
    assign data_rdata_o   = (w_data_resp & w_resp_has_data) ? ram_rdata_i : 32'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
            r_instr_cnt  <= '0;
            r_data_cnt   <= '0;
        end else begin
            if (!instr_req_i || w_instr_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (w_instr_gnt) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            if (w_data_gnt) begin
                r_data_cnt <= r_data_cnt + 1'b1;
            end
        end
    end

    assign instr_cnt_o = rst_i ? '0 : r_instr_cnt;
    assign data_cnt_o  = rst_i ? '0 : r_data_cnt;

endmodule

// File: tb/tb_biriscv_mem_arbiter.sv
// Directed bench: two arbiters (RAM latency 1 and 3) share one stimulus
// stream, each backed by its own behavioural RAM.
module tb_biriscv_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    logic        a_instr_gnt, a_instr_rvalid, a_instr_err;
    logic [31:0] a_instr_rdata;
    logic        a_data_gnt, a_data_rvalid, a_data_err;
    logic [31:0] a_data_rdata;
    logic        a_ram_req, a_ram_we;
    logic [19:0] a_ram_addr;
    logic [31:0] a_ram_wdata, a_ram_rdata;
    logic [3:0]  a_ram_strb;
    logic [31:0] a_instr_cnt, a_data_cnt;

    logic        b_instr_gnt, b_instr_rvalid, b_instr_err;
    logic [31:0] b_instr_rdata;
    logic        b_data_gnt, b_data_rvalid, b_data_err;
    logic [31:0] b_data_rdata;
    logic        b_ram_req, b_ram_we;
    logic [19:0] b_ram_addr;
    logic [31:0] b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_ram_strb;
    logic [31:0] b_instr_cnt, b_data_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    biriscv_mem_arbiter #(.ADDR_WIDTH(20), .RAM_LATENCY(1), .STARVE_MAX(8), .CNT_WIDTH(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(a_instr_gnt),
        .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata), .instr_err_o(a_instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(a_data_gnt), .data_rvalid_o(a_data_rvalid),
        .data_rdata_o(a_data_rdata), .data_err_o(a_data_err),
        .ram_req_o(a_ram_req), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr), .ram_wdata_o(a_ram_wdata),
        .ram_strb_o(a_ram_strb), .ram_rdata_i(a_ram_rdata),
        .instr_cnt_o(a_instr_cnt), .data_cnt_o(a_data_cnt)
    );

    biriscv_mem_arbiter #(.ADDR_WIDTH(20), .RAM_LATENCY(3), .STARVE_MAX(8), .CNT_WIDTH(32)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(b_instr_gnt),
        .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
        .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
        .ram_req_o(b_ram_req), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr), .ram_wdata_o(b_ram_wdata),
        .ram_strb_o(b_ram_strb), .ram_rdata_i(b_ram_rdata),
        .instr_cnt_o(b_instr_cnt), .data_cnt_o(b_data_cnt)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h40) return 32'h0000_0013;
        if (i == 'h80) return 32'h1122_3344;
        return 32'hA000_0000 | 32'(i);
    endfunction

    // Write cycles leave junk on rdata so the arbiter's zeroing is observable
    logic [31:0] a_mem [0:1023];
    logic [31:0] a_rd;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) a_mem[i] <= init_word(i);
        end else if (a_ram_req && a_ram_we) begin
            for (int k = 0; k < 4; k++)
                if (a_ram_strb[k]) a_mem[a_ram_addr[9:0]][8*k +: 8] <= a_ram_wdata[8*k +: 8];
        end
        a_rd <= (a_ram_req && !a_ram_we) ? a_mem[a_ram_addr[9:0]] : 32'hDEAD_BEEF;
    end
    assign a_ram_rdata = a_rd;

    logic [31:0] b_mem [0:1023];
    logic [31:0] b_rd [0:2];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) b_mem[i] <= init_word(i);
        end else if (b_ram_req && b_ram_we) begin
            for (int k = 0; k < 4; k++)
                if (b_ram_strb[k]) b_mem[b_ram_addr[9:0]][8*k +: 8] <= b_ram_wdata[8*k +: 8];
        end
        b_rd[0] <= (b_ram_req && !b_ram_we) ? b_mem[b_ram_addr[9:0]] : 32'hDEAD_BEEF;
        b_rd[1] <= b_rd[0];
        b_rd[2] <= b_rd[1];
    end
    assign b_ram_rdata = b_rd[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        instr_req  = 1'b0;
        instr_addr = 32'd0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 4'hF;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
    endtask

    // Latency-3 alternating schedule: 1 = fetch, 2 = data read
    int          s_kind [8] = '{1, 2, 1, 2, 0, 0, 0, 0};
    logic [31:0] s_addr [8] = '{32'h100, 32'h200, 32'h104, 32'h00C, 0, 0, 0, 0};
    int          e_kind [8] = '{0, 0, 0, 1, 2, 1, 2, 0};
    logic [31:0] e_data [8] = '{0, 0, 0, 32'h0000_0013, 32'h1122_CCDD, 32'hA000_0041, 32'hA000_0003, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst        = 1'b1;
        instr_req  = 1'b1;
        instr_addr = 32'h100;
        step(); step(); #1;
        chk("rst_instr_gnt", 32'(a_instr_gnt), 32'd0);
        chk("rst_ram_req",   32'(a_ram_req),   32'd0);
        chk("rst_ram_strb",  32'(a_ram_strb),  32'd0);
        chk("rst_instr_cnt", a_instr_cnt,      32'd0);
        step();
        rst = 1'b0;
        set_idle();
        step();

        // single fetch, latency 1
        instr_req  = 1'b1;
        instr_addr = 32'h100;
        #1;
        chk("fetch_gnt",      32'(a_instr_gnt), 32'd1);
        chk("fetch_ram_req",  32'(a_ram_req),   32'd1);
        chk("fetch_ram_addr", 32'(a_ram_addr),  32'h40);
        chk("fetch_ram_we",   32'(a_ram_we),    32'd0);
        step();
        set_idle();
        #1;
        chk("fetch_rvalid", 32'(a_instr_rvalid), 32'd1);
        chk("fetch_rdata",  a_instr_rdata,       32'h0000_0013);
        chk("fetch_err",    32'(a_instr_err),    32'd0);
        chk("fetch_cnt",    a_instr_cnt,         32'd1);
        repeat (4) step();

        // both ports requesting: seven data grants then one forced fetch
        instr_req  = 1'b1;
        instr_addr = 32'h100;
        data_req   = 1'b1;
        data_addr  = 32'h200;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("starve_data_gnt_%0d", k),  32'(a_data_gnt),  (k < 7) ? 32'd1 : 32'd0);
            chk($sformatf("starve_instr_gnt_%0d", k), 32'(a_instr_gnt), (k == 7) ? 32'd1 : 32'd0);
            step();
        end
        set_idle();
        #1;
        chk("starve_resp_instr", 32'(a_instr_rvalid), 32'd1);
        chk("starve_resp_rdata", a_instr_rdata,       32'h0000_0013);
        chk("starve_resp_data",  32'(a_data_rvalid),  32'd0);
        chk("starve_nonowner",   a_data_rdata,        32'd0);
        chk("starve_instr_cnt",  a_instr_cnt,         32'd2);
        chk("starve_data_cnt",   a_data_cnt,          32'd7);
        repeat (4) step();

        // partial write then read-back
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'b0011;
        data_addr  = 32'h200;
        data_wdata = 32'hAABB_CCDD;
        #1;
        chk("wr_gnt",      32'(a_data_gnt), 32'd1);
        chk("wr_ram_we",   32'(a_ram_we),   32'd1);
        chk("wr_ram_strb", 32'(a_ram_strb), 32'h3);
        chk("wr_ram_addr", 32'(a_ram_addr), 32'h80);
        chk("wr_ram_wdata", a_ram_wdata,    32'hAABB_CCDD);
        step();
        data_we    = 1'b0;
        data_be    = 4'hF;
        data_wdata = 32'd0;
        #1;
        chk("wr_rvalid", 32'(a_data_rvalid), 32'd1);
        chk("wr_rdata",  a_data_rdata,       32'd0);
        chk("rd_ram_we", 32'(a_ram_we),      32'd0);
        step();
        set_idle();
        #1;
        chk("rd_rvalid", 32'(a_data_rvalid), 32'd1);
        chk("rd_rdata",  a_data_rdata,       32'h1122_CCDD);
        repeat (4) step();

        // out-of-range read, then the highest in-range word
        data_req  = 1'b1;
        data_addr = 32'h0040_0000;
        #1;
        chk("oor_gnt",     32'(a_data_gnt), 32'd1);
        chk("oor_ram_req", 32'(a_ram_req),  32'd0);
        step();
        data_addr = 32'h003F_FFFC;
        #1;
        chk("oor_rvalid",    32'(a_data_rvalid), 32'd1);
        chk("oor_err",       32'(a_data_err),    32'd1);
        chk("oor_rdata",     a_data_rdata,       32'd0);
        chk("top_ram_req",   32'(a_ram_req),     32'd1);
        chk("top_ram_addr",  32'(a_ram_addr),    32'hF_FFFF);
        step();
        set_idle();
        #1;
        chk("top_rvalid", 32'(a_data_rvalid), 32'd1);
        chk("top_err",    32'(a_data_err),    32'd0);
        chk("top_rdata",  a_data_rdata,       32'hA000_03FF);
        step();
        #1;
        chk("oor_l3_rvalid", 32'(b_data_rvalid), 32'd1);
        chk("oor_l3_err",    32'(b_data_err),    32'd1);
        chk("oor_l3_ierr",   32'(b_instr_err),   32'd0);
        repeat (4) step();

        // alternating owners through the latency-3 instance
        for (int c = 0; c < 8; c++) begin
            set_idle();
            if (s_kind[c] == 1) begin
                instr_req  = 1'b1;
                instr_addr = s_addr[c];
            end else if (s_kind[c] == 2) begin
                data_req  = 1'b1;
                data_addr = s_addr[c];
            end
            #1;
            chk($sformatf("alt_ivalid_%0d", c), 32'(b_instr_rvalid), (e_kind[c] == 1) ? 32'd1 : 32'd0);
            chk($sformatf("alt_irdata_%0d", c), b_instr_rdata,       (e_kind[c] == 1) ? e_data[c] : 32'd0);
            chk($sformatf("alt_dvalid_%0d", c), 32'(b_data_rvalid),  (e_kind[c] == 2) ? 32'd1 : 32'd0);
            chk($sformatf("alt_drdata_%0d", c), b_data_rdata,        (e_kind[c] == 2) ? e_data[c] : 32'd0);
            step();
        end
        set_idle();
        repeat (4) step();

        // reset one cycle after a granted read drops its response
        data_req  = 1'b1;
        data_addr = 32'h200;
        #1;
        chk("rstmid_gnt", 32'(b_data_gnt), 32'd1);
        step();
        set_idle();
        rst = 1'b1;
        #1;
        chk("rstmid_a_rvalid", 32'(a_data_rvalid), 32'd0);
        chk("rstmid_b_rvalid", 32'(b_data_rvalid), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rstmid_dvalid_%0d", c), 32'(b_data_rvalid),  32'd0);
            chk($sformatf("rstmid_ivalid_%0d", c), 32'(b_instr_rvalid), 32'd0);
            step();
        end
        #1;
        chk("rstmid_b_dcnt", b_data_cnt,  32'd0);
        chk("rstmid_b_icnt", b_instr_cnt, 32'd0);
        chk("rstmid_a_icnt", a_instr_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
